// File: rtl/spi_master_ctrl.sv
// SPI mode 0 master: byte-wide handshake in, SCK/SSEL/MOSI out, MISO captured back.
// Multi-byte frames keep SSEL low between bytes until a byte flagged last is sent.
module spi_master_ctrl #(
  parameter int HALF = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       SCK,
  output logic       SSEL,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [7:0] DIV_MAX = 8'(HALF - 1);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, HOLD, TRAIL, GUARD} state_t;

  state_t     state, state_next;
  logic [7:0] div, div_next;
  logic [2:0] bit_cnt, bit_next;
  logic [7:0] tx_shift, tx_shift_next;
  logic [7:0] rx_shift, rx_shift_next;
  logic       last, last_next;
  logic       sck_next, ssel_next, mosi_next;
  logic       ready_next, rx_valid_next, busy_next;
  logic [7:0] rx_data_next;
  logic       accept;
  logic       div_end;

  // Every output is a register, so the whole next-cycle picture is built here.
  always_comb begin
    state_next    = state;
    div_next      = div;
    bit_next      = bit_cnt;
    tx_shift_next = tx_shift;
    rx_shift_next = rx_shift;
    last_next     = last;
    sck_next      = SCK;
    ssel_next     = SSEL;
    mosi_next     = MOSI;
    ready_next    = tx_ready;
    rx_valid_next = 1'b0;
    rx_data_next  = rx_data;
    accept        = tx_valid && tx_ready;
    div_end       = (div == DIV_MAX);

    case (state)
      IDLE, HOLD: begin
        ready_next = 1'b1;
        sck_next   = 1'b0;
        if (state == IDLE) begin
          ssel_next = 1'b1;
          mosi_next = 1'b0;
        end
        if (accept) begin
          tx_shift_next = tx_data;
          last_next     = tx_last;
          mosi_next     = tx_data[7];
          ssel_next     = 1'b0;
          ready_next    = 1'b0;
          div_next      = 8'd0;
          state_next    = LEAD;
        end
      end

      LEAD: begin
        if (div_end) begin
          div_next   = 8'd0;
          state_next = SHIFT;
        end else begin
          div_next = div + 8'd1;
        end
      end

      // MISO is taken on the final clk of the high phase, just before SCK falls.
      SHIFT: begin
        if (!div_end) begin
          div_next = div + 8'd1;
        end else begin
          div_next = 8'd0;
          if (!SCK) begin
            sck_next = 1'b1;
          end else begin
            sck_next      = 1'b0;
            rx_shift_next = {rx_shift[6:0], MISO};
            bit_next      = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_next  = {rx_shift[6:0], MISO};
              rx_valid_next = 1'b1;
              mosi_next     = 1'b0;
              ready_next    = !last;
              state_next    = last ? TRAIL : HOLD;
            end else begin
              tx_shift_next = {tx_shift[6:0], 1'b0};
              mosi_next     = tx_shift[6];
            end
          end
        end
      end

      TRAIL: begin
        if (div_end) begin
          div_next   = 8'd0;
          ssel_next  = 1'b1;
          state_next = GUARD;
        end else begin
          div_next = div + 8'd1;
        end
      end

      GUARD: begin
        if (div_end) begin
          div_next   = 8'd0;
          ready_next = 1'b1;
          state_next = IDLE;
        end else begin
          div_next = div + 8'd1;
        end
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      div      <= 8'd0;
      bit_cnt  <= 3'd0;
      tx_shift <= 8'd0;
      rx_shift <= 8'd0;
      last     <= 1'b0;
      SCK      <= 1'b0;
      SSEL     <= 1'b1;
      MOSI     <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= 8'd0;
      busy     <= 1'b0;
    end else begin
      state    <= state_next;
      div      <= div_next;
      bit_cnt  <= bit_next;
      tx_shift <= tx_shift_next;
      rx_shift <= rx_shift_next;
      last     <= last_next;
      SCK      <= sck_next;
      SSEL     <= ssel_next;
      MOSI     <= mosi_next;
      tx_ready <= ready_next;
      rx_valid <= rx_valid_next;
      rx_data  <= rx_data_next;
      busy     <= busy_next;
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: four instances with different HALF values,
// each with its own stimulus, SPI slave model and timing/data monitor.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic void check_output(input int h, input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL H=%0d %s: got %0d expected %0d", h, name, act, exp);
    end
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int H = (g == 0) ? 4 : (g == 1) ? 2 : (g == 2) ? 3 : 7;

    logic       rst_n    = 1'b0;
    logic       tx_valid = 1'b0;
    logic       tx_last  = 1'b0;
    logic [7:0] tx_data  = 8'd0;
    logic       tx_ready, rx_valid, busy, sck, ssel, mosi, miso;
    logic [7:0] rx_data;
    logic       loop  = 1'b0;
    logic [7:0] sreg  = 8'd0;
    bit         abort = 1'b0;
    bit         fin   = 1'b0;
    logic [7:0] slave_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] tx_q[$];

    assign miso = loop ? mosi : sreg[7];

    spi_master_ctrl #(.HALF(H)) dut (
      .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
      .tx_last(tx_last), .tx_ready(tx_ready), .rx_valid(rx_valid),
      .rx_data(rx_data), .busy(busy), .SCK(sck), .SSEL(ssel),
      .MOSI(mosi), .MISO(miso)
    );

    // Mode 0 slave: presents MSB once selected, advances on each SCK falling edge.
    initial begin : slave
      bit   have = 1'b0;
      int   nb   = 0;
      logic psck = 1'b0;
      forever begin
        @(negedge clk);
        if (ssel) begin
          have = 1'b0;
          nb   = 0;
        end else begin
          if (psck && !sck) begin
            sreg = {sreg[6:0], 1'b0};
            nb++;
            if (nb == 8) begin
              have = 1'b0;
              nb   = 0;
            end
          end
          if (!have && slave_q.size() > 0) begin
            sreg = slave_q.pop_front();
            have = 1'b1;
          end
        end
        psck = sck;
      end
    end

    // Monitor: scoreboard pops, MOSI bit collection and phase-length timing.
    initial begin : monitor
      logic       psck = 1'b0, pssel = 1'b1, prdy = 1'b0;
      int         cyc = 0, run = 0, acc_cyc = 0, rx_cyc = 0, rise_cyc = 0, nbits = 0;
      bit         guard_pend = 1'b0;
      logic [7:0] bits = 8'd0;
      forever begin
        @(negedge clk);
        cyc++;
        if (prdy && !tx_ready && !ssel) acc_cyc = cyc;
        if (rx_valid) begin
          rx_cyc = cyc;
          check_output(H, "accept-to-rx_valid cycles", cyc - acc_cyc, 17 * H);
          if (rx_q.size() == 0) check_output(H, "unexpected rx_valid", 1, 0);
          else check_output(H, "rx_data", int'(rx_data), int'(rx_q.pop_front()));
        end
        if (sck) run++;
        else if (psck) begin
          if (!abort) check_output(H, "SCK high length", run, H);
          run = 0;
        end
        if (ssel) nbits = 0;
        else if (sck && !psck) begin
          bits = {bits[6:0], mosi};
          nbits++;
          if (nbits == 8) begin
            nbits = 0;
            if (tx_q.size() == 0) check_output(H, "unexpected MOSI byte", 1, 0);
            else check_output(H, "MOSI byte", int'(bits), int'(tx_q.pop_front()));
          end
        end
        if (ssel && !pssel && !abort) begin
          check_output(H, "trail length", cyc - rx_cyc, H);
          rise_cyc   = cyc;
          guard_pend = 1'b1;
        end
        if (tx_ready && !prdy && guard_pend) begin
          check_output(H, "guard length", cyc - rise_cyc, H);
          guard_pend = 1'b0;
        end
        if (abort) guard_pend = 1'b0;
        psck  = sck;
        pssel = ssel;
        prdy  = tx_ready;
      end
    end

    task automatic wait_ready();
      int n = 0;
      while (!tx_ready && n <= 40 * H) begin
        @(negedge clk);
        n++;
      end
      check_output(H, "tx_ready reached", int'(tx_ready), 1);
    endtask

    task automatic wait_idle();
      int n = 0;
      while ((busy || !tx_ready) && n <= 60 * H) begin
        @(negedge clk);
        n++;
      end
      check_output(H, "idle reached", int'(!busy && tx_ready), 1);
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic last,
                                  input logic [7:0] sv, input bit track);
      wait_ready();
      if (!loop) slave_q.push_back(sv);
      if (track) begin
        rx_q.push_back(loop ? d : sv);
        tx_q.push_back(d);
      end
      tx_valid = 1'b1;
      tx_data  = d;
      tx_last  = last;
      @(negedge clk);
      tx_valid = 1'b0;
      tx_data  = 8'($urandom);
      tx_last  = 1'($urandom);
    endtask

    initial begin : stim
      bit         bad;
      int         n, r;
      logic       ps;
      logic [7:0] d;
      int         nb;

      repeat (2) @(negedge clk);
      check_output(H, "reset SSEL", int'(ssel), 1);
      check_output(H, "reset SCK", int'(sck), 0);
      check_output(H, "reset MOSI", int'(mosi), 0);
      check_output(H, "reset tx_ready", int'(tx_ready), 0);
      check_output(H, "reset rx_valid", int'(rx_valid), 0);
      check_output(H, "reset busy", int'(busy), 0);
      check_output(H, "reset rx_data", int'(rx_data), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check_output(H, "tx_ready after reset", int'(tx_ready), 1);

      apply_stimulus(8'hA5, 1'b1, 8'h3C, 1'b1);
      wait_idle();

      apply_stimulus(8'h12, 1'b0, 8'($urandom), 1'b1);
      wait_ready();
      bad = 1'b0;
      repeat (10) begin
        if (ssel || sck || !tx_ready) bad = 1'b1;
        @(negedge clk);
      end
      check_output(H, "HOLD keeps SSEL low, SCK low, ready", int'(bad), 0);
      apply_stimulus(8'h34, 1'b1, 8'($urandom), 1'b1);
      wait_idle();

      // tx_valid left asserted while the block is busy must not start another byte.
      wait_ready();
      d = 8'($urandom);
      slave_q.push_back(8'h5A);
      rx_q.push_back(8'h5A);
      tx_q.push_back(d);
      tx_valid = 1'b1;
      tx_data  = d;
      tx_last  = 1'b1;
      @(negedge clk);
      tx_data = ~d;
      bad = 1'b0;
      n = 0;
      while (!tx_ready && n <= 40 * H) begin
        if (!busy) bad = 1'b1;
        @(negedge clk);
        n++;
      end
      tx_valid = 1'b0;
      check_output(H, "busy held until guard ends", int'(bad), 0);
      check_output(H, "busy low on return to idle", int'(busy), 0);

      apply_stimulus(8'($urandom), 1'b1, 8'($urandom), 1'b0);
      r = 0;
      n = 0;
      ps = sck;
      while (r < 3 && n < 40 * H) begin
        @(negedge clk);
        if (sck && !ps) r++;
        ps = sck;
        n++;
      end
      while (sck && n < 40 * H) begin
        @(negedge clk);
        n++;
      end
      check_output(H, "reached bit 3", r, 3);
      abort = 1'b1;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_output(H, "abort SSEL", int'(ssel), 1);
      check_output(H, "abort SCK", int'(sck), 0);
      check_output(H, "abort tx_ready", int'(tx_ready), 0);
      check_output(H, "abort rx_valid", int'(rx_valid), 0);
      @(negedge clk);
      check_output(H, "tx_ready after abort", int'(tx_ready), 1);
      abort = 1'b0;

      apply_stimulus(8'hFF, 1'b1, 8'h00, 1'b1);
      wait_idle();

      loop = 1'b1;
      for (int f = 0; f < 5; f++) begin
        nb = int'($urandom_range(1, 3));
        for (int b = 0; b < nb; b++) begin
          apply_stimulus(8'($urandom), 1'(b == nb - 1), 8'd0, 1'b1);
          repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();
      end

      repeat (5) @(negedge clk);
      check_output(H, "rx bytes outstanding", rx_q.size(), 0);
      check_output(H, "MOSI bytes outstanding", tx_q.size(), 0);
      fin = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(g_dut[0].fin && g_dut[1].fin && g_dut[2].fin && g_dut[3].fin) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check_output(0, "all instances finished", int'(g_dut[0].fin && g_dut[1].fin &&
                 g_dut[2].fin && g_dut[3].fin), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
